// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 1440x900@60 raster timing generator gated by PLL lock
module vga_timing_gen #(
   parameter int H_VISIBLE   = 1440,
   parameter int H_FP        = 80,
   parameter int H_SYNC      = 152,
   parameter int H_BP        = 232,
   parameter int V_VISIBLE   = 900,
   parameter int V_FP        = 1,
   parameter int V_SYNC      = 3,
   parameter int V_BP        = 28,
   parameter bit H_SYNC_POL  = 1'b0,
   parameter bit V_SYNC_POL  = 1'b1,
   parameter int LOCK_SETTLE = 4096
) (
   input  logic        refclk,
   input  logic        rst,
   input  logic        locked,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        line_start,
   output logic        frame_start,
   output logic        running
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int SW      = (LOCK_SETTLE > 2) ? $clog2(LOCK_SETTLE) : 1;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

   typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

   state_t        state_q, state_d;
   logic          lk_meta_q, lk_meta_d;
   logic          lk_s_q, lk_s_d;
   logic [SW-1:0] settle_cnt_q, settle_cnt_d;
   logic [10:0]   h_cnt_q, h_cnt_d;
   logic [9:0]    v_cnt_q, v_cnt_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic [10:0]   x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          running_q, running_d;

   always_comb begin
      lk_meta_d    = locked;
      lk_s_d       = lk_meta_q;
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      h_cnt_d      = h_cnt_q;
      v_cnt_d      = v_cnt_q;

      case (state_q)
         WAIT_LOCK: begin
            settle_cnt_d = '0;
            h_cnt_d      = '0;
            v_cnt_d      = '0;
            // The cycle that first sees lock counts as the first settled cycle.
            if (lk_s_q) begin
               state_d      = SETTLE;
               settle_cnt_d = SW'(1);
            end
         end
         SETTLE: begin
            if (!lk_s_q) begin
               state_d      = WAIT_LOCK;
               settle_cnt_d = '0;
            end else if (settle_cnt_q == SETTLE_LAST) begin
               state_d      = RUN;
               settle_cnt_d = '0;
            end else begin
               settle_cnt_d = settle_cnt_q + SW'(1);
            end
         end
         RUN: begin
            if (!lk_s_q) begin
               state_d = WAIT_LOCK;
               h_cnt_d = '0;
               v_cnt_d = '0;
            end else if (h_cnt_q == H_LAST) begin
               h_cnt_d = '0;
               v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
               h_cnt_d = h_cnt_q + 11'd1;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   // Outputs decode the counters of the previous cycle and go idle unless that cycle was RUN.
   always_comb begin
      hsync_d       = ~H_SYNC_POL;
      vsync_d       = ~V_SYNC_POL;
      de_d          = 1'b0;
      x_d           = '0;
      y_d           = '0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      running_d     = (state_d == RUN);
      if (state_q == RUN) begin
         de_d          = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
         x_d           = de_d ? h_cnt_q : 11'd0;
         y_d           = de_d ? v_cnt_q : 10'd0;
         hsync_d       = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
         vsync_d       = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
         line_start_d  = (h_cnt_q == 11'd0);
         frame_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q       <= WAIT_LOCK;
         lk_meta_q     <= 1'b0;
         lk_s_q        <= 1'b0;
         settle_cnt_q  <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= ~H_SYNC_POL;
         vsync_q       <= ~V_SYNC_POL;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         lk_meta_q     <= lk_meta_d;
         lk_s_q        <= lk_s_d;
         settle_cnt_q  <= settle_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         running_q     <= running_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign running     = running_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumer end of the VGA pixel-clock PLL; runs on the 106.481481 MHz PLL output and takes the PLL `locked` flag as an input.
- Qualifies `locked` before starting, then generates 1440x900@60 raster timing: hsync, vsync, data-enable, pixel/line coordinates, line/frame strobes.
- Feeds the oscilloscope trace renderer and the VGA DAC pins.
- Halts the raster cleanly whenever the PLL loses lock.

Parameters:
- H_VISIBLE, 1440, active pixels per line
- H_FP, 80, horizontal front porch (pixels)
- H_SYNC, 152, hsync width (pixels)
- H_BP, 232, horizontal back porch (pixels); H_TOTAL = 1904
- V_VISIBLE, 900, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 28, vertical back porch (lines); V_TOTAL = 932
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 1, vsync active level (1 = active-high)
- LOCK_SETTLE, 4096, consecutive locked cycles required before the raster starts (16 in simulation)

Ports:
- refclk  in  1  pixel clock (PLL outclk_0)
- rst  in  1  reset, asynchronous, active-high
- locked  in  1  PLL lock flag; asynchronous to refclk
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- de  out  1  high during visible pixels
- x  out  11  pixel column, 0..H_VISIBLE-1 when de, else 0
- y  out  10  pixel row, 0..V_VISIBLE-1 when de, else 0
- line_start  out  1  1-cycle pulse at h=0 of every line, visible or blanking
- frame_start  out  1  1-cycle pulse at h=0, v=0
- running  out  1  high while in state RUN

Behaviour:
- One clock domain, refclk. `rst` is asynchronous and active-high; every flop is cleared by it.
- Reset and idle values:
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL
  - de = 0, x = 0, y = 0
  - line_start = 0, frame_start = 0, running = 0
  - internal counters h_cnt = 0, v_cnt = 0, settle_cnt = 0
- Lock input: `locked` passes through a 2-flop synchronizer giving lk_s, so it is seen 2 cycles late.
- FSM WAIT_LOCK:
  - settle_cnt = 0, counters held at 0.
  - lk_s = 1 -> SETTLE.
- FSM SETTLE:
  - settle_cnt increments each cycle while lk_s = 1.
  - lk_s = 0 -> WAIT_LOCK, settle_cnt cleared.
  - settle_cnt = LOCK_SETTLE-1 with lk_s = 1 -> RUN.
- FSM RUN:
  - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - On h wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - lk_s = 0 -> WAIT_LOCK. Counters clear to 0 the next cycle and outputs return to idle values one cycle after that. There is no partial-frame completion.
- Timing of the first frame: the first RUN cycle has h_cnt = 0, v_cnt = 0. `running` is registered, so it rises on that same first RUN cycle.
- Output latency: every output except `running` is registered from (h_cnt, v_cnt) with exactly 1 cycle latency, so all are mutually aligned.
- Output decode (h = h_cnt, v = v_cnt):
  - de = (h < H_VISIBLE) and (v < V_VISIBLE)
  - x = h when de, else 0; y = v when de, else 0
  - hsync active when H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC, i.e. h = 1520..1671
  - vsync active when V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC, i.e. lines 901..903, for the whole line
  - line_start = (h = 0); frame_start = (h = 0 and v = 0)
- Outside RUN, all outputs hold idle values, including in the cycle where RUN is exited.
- Widths: h_cnt is 11 bits, v_cnt is 10 bits. Comparisons are unsigned. Wrap is by compare-to-total, never by natural overflow.
- A rst assertion at any point, including mid-frame, immediately forces idle outputs and WAIT_LOCK.

Test Plan:
1. Reset, LOCK_SETTLE = 16, `locked` held 1 -> `running` rises 18 cycles after rst deassert (2 sync + 16 settle). frame_start pulses the next cycle with x = 0, y = 0, de = 1.
2. Free-run 2 frames -> frame_start period is 1904*932 = 1774528 cycles and line_start period is 1904. de is high for 1440 cycles per line on 900 lines per frame, i.e. 1296000 cycles per frame.
3. Sync positions -> hsync low for cycles 1520..1671 of each line (152 cycles). vsync high for 3 full lines starting at line 901. x = 1439 on the last de cycle; y = 899 on the final visible line.
4. `locked` glitches low for 1 cycle during SETTLE -> settle count restarts and `running` rises a full 16 cycles after lock returns.
5. `locked` drops mid-frame at line 450 -> `running` drops and all outputs reach idle values within 4 cycles. After lock returns, the raster restarts at (0,0) with a fresh frame_start.
6. rst pulsed asynchronously mid-line (not clock-aligned) -> outputs idle immediately. Restart follows the scenario 1 timing.
